// File: rtl/pipe_seg_skid.sv
// rtl/pipe_seg_skid.sv - pipeline segment register with valid/ready handshake and 2-entry skid buffer
// Control field is always cleared on flush; data field clearing is selected by CLEAR_DATA.
module pipe_seg_skid #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 8,
  parameter int CLEAR_DATA = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        count
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_live;
  logic [DATA_W-1:0]   r_main_data;
  logic [CTRL_W-1:0]   r_main_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;

  logic                w_accept;
  logic                w_emit;

  // r_live keeps in_ready low while reset is held and until the first edge after release.
  assign in_ready  = r_live & ~stall & (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign count     = r_state;
  assign out_data  = r_main_data;
  assign out_ctrl  = r_main_ctrl;

  assign w_accept  = in_valid & in_ready;
  assign w_emit    = out_valid & out_ready & ~stall;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= EMPTY;
      r_live      <= 1'b0;
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else begin
      r_live <= 1'b1;
      if (flush) begin
        r_state     <= EMPTY;
        r_main_ctrl <= '0;
        r_skid_ctrl <= '0;
        if (CLEAR_DATA != 0) begin
          r_main_data <= '0;
          r_skid_data <= '0;
        end
      end else if (!stall) begin
        case (r_state)
          EMPTY: begin
            if (w_accept) begin
              r_main_data <= in_data;
              r_main_ctrl <= in_ctrl;
              r_state     <= BUSY;
            end
          end
          BUSY: begin
            if (w_accept && !w_emit) begin
              r_skid_data <= in_data;
              r_skid_ctrl <= in_ctrl;
              r_state     <= FULL;
            end else if (w_accept && w_emit) begin
              r_main_data <= in_data;
              r_main_ctrl <= in_ctrl;
            end else if (w_emit) begin
              r_state <= EMPTY;
            end
          end
          FULL: begin
            if (w_emit) begin
              r_main_data <= r_skid_data;
              r_main_ctrl <= r_skid_ctrl;
              r_state     <= BUSY;
            end
          end
          default: r_state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_seg_skid.sv
// tb/tb_pipe_seg_skid.sv - directed table-driven bench for pipe_seg_skid
// Two instances share stimulus: one clears data on flush, one holds it.
module tb_pipe_seg_skid;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        stall, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;

  logic        in_ready_c, out_valid_c;
  logic [31:0] out_data_c;
  logic [7:0]  out_ctrl_c;
  logic [1:0]  count_c;

  logic        in_ready_k, out_valid_k;
  logic [31:0] out_data_k;
  logic [7:0]  out_ctrl_k;
  logic [1:0]  count_k;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pipe_seg_skid #(.DATA_W(32), .CTRL_W(8), .CLEAR_DATA(1)) dut_clr (
    .Clk(Clk), .Rst_n(Rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
    .out_ctrl(out_ctrl_c), .count(count_c)
  );

  pipe_seg_skid #(.DATA_W(32), .CTRL_W(8), .CLEAR_DATA(0)) dut_keep (
    .Clk(Clk), .Rst_n(Rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_k), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid_k), .out_ready(out_ready), .out_data(out_data_k),
    .out_ctrl(out_ctrl_k), .count(count_k)
  );

  // Expected values describe the outputs just before the edge that consumes the inputs.
  typedef struct {
    logic        st, fl, iv;
    logic [31:0] d;
    logic [7:0]  c;
    logic        ordy;
    logic        ir, ov;
    logic [31:0] od, odk;
    logic [7:0]  oc;
    logic [1:0]  cnt;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic st, logic fl, logic iv, logic [31:0] d, logic [7:0] c,
                              logic ordy, logic ir, logic ov, logic [31:0] od,
                              logic [31:0] odk, logic [7:0] oc, logic [1:0] cnt);
    vec_t v;
    v.st = st; v.fl = fl; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
    v.ir = ir; v.ov = ov; v.od = od; v.odk = odk; v.oc = oc; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic iv, input logic [31:0] d,
                       input logic [7:0] c, input logic ordy);
    stall = st; flush = fl; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
  endtask

  initial begin
    Rst_n = 1'b0;
    drive(0, 0, 0, 32'h0, 8'h0, 0);

    //          st fl iv data     ctrl   ordy ir ov od       odk      oc     cnt
    tbl[0]  = mk(0, 0, 1, 32'h11, 8'h01, 1,   1, 0, 32'h0,   32'h0,   8'h00, 2'd0);
    tbl[1]  = mk(0, 0, 1, 32'h22, 8'h02, 1,   1, 1, 32'h11,  32'h11,  8'h01, 2'd1);
    tbl[2]  = mk(0, 0, 1, 32'h33, 8'h03, 1,   1, 1, 32'h22,  32'h22,  8'h02, 2'd1);
    tbl[3]  = mk(0, 0, 1, 32'h44, 8'h04, 1,   1, 1, 32'h33,  32'h33,  8'h03, 2'd1);
    tbl[4]  = mk(0, 0, 0, 32'h0,  8'h00, 1,   1, 1, 32'h44,  32'h44,  8'h04, 2'd1);
    tbl[5]  = mk(0, 0, 1, 32'hA1, 8'h11, 0,   1, 0, 32'h44,  32'h44,  8'h04, 2'd0);
    tbl[6]  = mk(0, 0, 1, 32'hA2, 8'h12, 0,   1, 1, 32'hA1,  32'hA1,  8'h11, 2'd1);
    tbl[7]  = mk(0, 0, 1, 32'hA3, 8'h13, 0,   0, 1, 32'hA1,  32'hA1,  8'h11, 2'd2);
    tbl[8]  = mk(0, 0, 1, 32'hA3, 8'h13, 1,   0, 1, 32'hA1,  32'hA1,  8'h11, 2'd2);
    tbl[9]  = mk(0, 0, 1, 32'hA3, 8'h13, 1,   1, 1, 32'hA2,  32'hA2,  8'h12, 2'd1);
    tbl[10] = mk(0, 0, 0, 32'h0,  8'h00, 1,   1, 1, 32'hA3,  32'hA3,  8'h13, 2'd1);
    tbl[11] = mk(0, 0, 1, 32'hB1, 8'hFF, 0,   1, 0, 32'hA3,  32'hA3,  8'h13, 2'd0);
    tbl[12] = mk(0, 0, 1, 32'hB2, 8'hFF, 0,   1, 1, 32'hB1,  32'hB1,  8'hFF, 2'd1);
    tbl[13] = mk(0, 1, 1, 32'hB3, 8'hFF, 0,   0, 1, 32'hB1,  32'hB1,  8'hFF, 2'd2);
    tbl[14] = mk(0, 0, 1, 32'h55, 8'h05, 0,   1, 0, 32'h0,   32'hB1,  8'h00, 2'd0);
    tbl[15] = mk(1, 0, 1, 32'h66, 8'h06, 1,   0, 1, 32'h55,  32'h55,  8'h05, 2'd1);
    tbl[16] = mk(1, 0, 1, 32'h66, 8'h06, 1,   0, 1, 32'h55,  32'h55,  8'h05, 2'd1);
    tbl[17] = mk(1, 0, 1, 32'h66, 8'h06, 1,   0, 1, 32'h55,  32'h55,  8'h05, 2'd1);
    tbl[18] = mk(0, 0, 0, 32'h0,  8'h00, 1,   1, 1, 32'h55,  32'h55,  8'h05, 2'd1);
    tbl[19] = mk(0, 0, 1, 32'h77, 8'h07, 0,   1, 0, 32'h55,  32'h55,  8'h05, 2'd0);
    tbl[20] = mk(1, 1, 1, 32'h88, 8'h08, 1,   0, 1, 32'h77,  32'h77,  8'h07, 2'd1);
    tbl[21] = mk(0, 0, 0, 32'h0,  8'h00, 0,   1, 0, 32'h0,   32'h77,  8'h00, 2'd0);

    repeat (2) @(negedge Clk);
    #1;
    chk("reset in_ready",  {31'd0, in_ready_c},  32'd0);
    chk("reset out_valid", {31'd0, out_valid_c}, 32'd0);
    chk("reset count",     {30'd0, count_c},     32'd0);
    chk("reset out_data",  out_data_c,           32'd0);
    chk("reset out_ctrl",  {24'd0, out_ctrl_c},  32'd0);

    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge Clk);
      drive(tbl[i].st, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy);
      #1;
      chk($sformatf("v%0d in_ready", i),       {31'd0, in_ready_c},  {31'd0, tbl[i].ir});
      chk($sformatf("v%0d out_valid", i),      {31'd0, out_valid_c}, {31'd0, tbl[i].ov});
      chk($sformatf("v%0d out_data", i),       out_data_c,           tbl[i].od);
      chk($sformatf("v%0d out_ctrl", i),       {24'd0, out_ctrl_c},  {24'd0, tbl[i].oc});
      chk($sformatf("v%0d count", i),          {30'd0, count_c},     {30'd0, tbl[i].cnt});
      chk($sformatf("v%0d keep out_data", i),  out_data_k,           tbl[i].odk);
      chk($sformatf("v%0d keep out_ctrl", i),  {24'd0, out_ctrl_k},  {24'd0, tbl[i].oc});
      chk($sformatf("v%0d keep count", i),     {30'd0, count_k},     {30'd0, tbl[i].cnt});
    end

    // Async reset while FULL: outputs must clear before the next clock edge.
    @(negedge Clk);
    drive(0, 0, 1, 32'hC1, 8'hAA, 0);
    @(negedge Clk);
    drive(0, 0, 1, 32'hC2, 8'hAB, 0);
    @(negedge Clk);
    drive(0, 0, 0, 32'h0, 8'h00, 0);
    #1;
    chk("arst pre count",    {30'd0, count_c},    32'd2);
    chk("arst pre out_ctrl", {24'd0, out_ctrl_c}, 32'hAA);
    #1;
    Rst_n = 1'b0;
    #1;
    chk("arst out_valid", {31'd0, out_valid_c}, 32'd0);
    chk("arst count",     {30'd0, count_c},     32'd0);
    chk("arst out_ctrl",  {24'd0, out_ctrl_c},  32'd0);
    chk("arst out_data",  out_data_c,           32'd0);
    chk("arst in_ready",  {31'd0, in_ready_c},  32'd0);
    chk("arst keep data", out_data_k,           32'd0);

    // After release, a single push appears one cycle later with the pushed value.
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    drive(0, 0, 1, 32'hD1, 8'h3C, 1);
    #1;
    chk("post in_ready", {31'd0, in_ready_c}, 32'd1);
    @(negedge Clk);
    drive(0, 0, 0, 32'h0, 8'h00, 1);
    #1;
    chk("post out_valid", {31'd0, out_valid_c}, 32'd1);
    chk("post out_data",  out_data_c,           32'hD1);
    chk("post out_ctrl",  {24'd0, out_ctrl_c},  32'h3C);
    @(negedge Clk);
    #1;
    chk("post drained", {30'd0, count_c}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
